rv_data_memory: RTL and testbench



---
 rtl/rv_pkg.sv | 14 +
 rtl/dmem_array.sv | 32 +++
 rtl/rv_data_memory.sv | 49 ++++
 tb/tb_rv_data_memory.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared constants and types for the RV core
package rv_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int BYTE_OFFSET_W = 2;

  typedef logic [DATA_WIDTH-1:0] word_t;

  // Word index for a byte address in a power-of-two word array; upper bits wrap
  function automatic int unsigned word_index(input logic [31:0] addr, input int unsigned depth);
    return (addr >> BYTE_OFFSET_W) & (depth - 1);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - flop-based word array with async clear, one write port, one async read port
module dmem_array
  import rv_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             wr_enable_i,
  input  logic [IDX_W-1:0] wr_index_i,
  input  word_t            wr_data_i,
  input  logic [IDX_W-1:0] rd_index_i,
  output word_t            rd_word_o
);

  word_t mem [DEPTH_WORDS];

  // Every word must clear on reset, which rules out a plain inferred RAM
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_enable_i) begin
      mem[wr_index_i] <= wr_data_i;
    end
  end

  assign rd_word_o = mem[rd_index_i];

endmodule

// File: rtl/rv_data_memory.sv
// rtl/rv_data_memory.sv - word-organised data memory with registered read port
module rv_data_memory
  import rv_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int DATA_WIDTH  = rv_pkg::DATA_WIDTH
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [31:0]           addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_enable_i,
  input  logic                  rd_enable_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [IDX_W-1:0] index;
  word_t            rd_word;
  logic             unused_addr_bits;

  // Byte offset and bits above the array size are dropped: misaligned and out-of-range accesses alias
  assign index            = addr_i[IDX_W+BYTE_OFFSET_W-1:BYTE_OFFSET_W];
  assign unused_addr_bits = ^{addr_i[31:IDX_W+BYTE_OFFSET_W], addr_i[BYTE_OFFSET_W-1:0]};

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .wr_enable_i(wr_enable_i),
    .wr_index_i (index),
    .wr_data_i  (wr_data_i),
    .rd_index_i (index),
    .rd_word_o  (rd_word)
  );

  // Sampling the pre-edge array contents gives read-before-write on a same-index collision
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rd_data_o <= '0;
    end else if (rd_enable_i) begin
      rd_data_o <= rd_word;
    end
  end

endmodule

// File: tb/tb_rv_data_memory.sv
// tb/tb_rv_data_memory.sv - randomized self-checking bench for rv_data_memory
module tb_rv_data_memory;

  localparam int DEPTH = 64;

  logic        clk;
  logic        reset_i;
  logic [31:0] addr_i;
  logic [31:0] wr_data_i;
  logic        wr_enable_i;
  logic        rd_enable_i;
  logic [31:0] rd_data_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_rd;

  rv_data_memory #(.DEPTH_WORDS(DEPTH)) dut (
    .clock_i    (clk),
    .reset_i    (reset_i),
    .addr_i     (addr_i),
    .wr_data_i  (wr_data_i),
    .wr_enable_i(wr_enable_i),
    .rd_enable_i(rd_enable_i),
    .rd_data_o  (rd_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    ref_rd = 32'h0;
  endtask

  // One clock: drive on the falling edge, update the model at the rising edge, compare just after
  task automatic cycle(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic we, input logic re);
    int idx;
    @(negedge clk);
    addr_i = a; wr_data_i = d; wr_enable_i = we; rd_enable_i = re;
    @(posedge clk);
    idx = int'((a / 4) % DEPTH);
    if (re) ref_rd = ref_mem[idx];
    if (we) ref_mem[idx] = d;
    #1;
    check(tag, rd_data_o, ref_rd);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cycle("write", a, d, 1'b1, 1'b0);
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    cycle(tag, a, 32'h0, 1'b0, 1'b1);
    check({tag, "_abs"}, rd_data_o, exp);
  endtask

  initial begin
    reset_i = 1'b1; addr_i = '0; wr_data_i = '0; wr_enable_i = 1'b0; rd_enable_i = 1'b0;
    ref_clear();
    repeat (2) @(posedge clk);
    #1 check("reset_rd", rd_data_o, 32'h0);
    @(negedge clk);
    reset_i = 1'b0;

    // Write then read, two write cycles each
    wr(0, 32'h5555_5555); wr(0, 32'h5555_5555);
    wr(4, 32'hAAAA_AAAA); wr(4, 32'hAAAA_AAAA);
    rd("rd_addr0", 0, 32'h5555_5555);
    rd("rd_addr4", 4, 32'hAAAA_AAAA);

    // Read hold across write-only cycles
    wr(4, 32'h0);
    check("hold_after_wr", rd_data_o, 32'hAAAA_AAAA);
    rd("rd_after_hold", 4, 32'h0);

    // Asynchronous reset mid-cycle
    wr(8, 32'hDEAD_BEEF);
    rd("rd_addr8", 8, 32'hDEAD_BEEF);
    @(negedge clk);
    #2 reset_i = 1'b1;
    #1 check("async_reset_rd", rd_data_o, 32'h0);
    addr_i = 8; wr_data_i = 32'hFFFF_FFFF; wr_enable_i = 1'b1; rd_enable_i = 1'b1;
    @(posedge clk);
    #1 check("reset_ignores_en", rd_data_o, 32'h0);
    @(negedge clk);
    reset_i = 1'b0; wr_enable_i = 1'b0; rd_enable_i = 1'b0;
    ref_clear();
    rd("rd_addr8_cleared", 8, 32'h0);
    rd("rd_addr0_cleared", 0, 32'h0);

    // Same-cycle read and write at one index
    wr(12, 32'h1111_1111);
    cycle("rw_same", 12, 32'h2222_2222, 1'b1, 1'b1);
    check("rw_same_old", rd_data_o, 32'h1111_1111);
    rd("rw_same_next", 12, 32'h2222_2222);

    // Alignment and wrap
    wr(16, 32'h1234_5678);
    rd("rd_addr17", 17, 32'h1234_5678);
    rd("rd_addr19", 19, 32'h1234_5678);
    rd("rd_wrap", 16 + 4 * DEPTH, 32'h1234_5678);

    // Idle
    for (int i = 0; i < 10; i++) cycle("idle", $urandom, $urandom, 1'b0, 1'b0);
    check("idle_hold", rd_data_o, 32'h1234_5678);
    rd("idle_mem12", 12, 32'h2222_2222);

    // Random traffic, addresses biased to a few words to provoke collisions
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? $urandom : {$urandom_range(0, 3), 4'h0} | 32'($urandom_range(0, 3));
      cycle("random", a, $urandom, 1'($urandom), 1'($urandom));
    end

    // Full sweep against the model
    for (int i = 0; i < DEPTH; i++) cycle("sweep", 32'(i * 4), 32'h0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
